// File: rtl/tcsm_stream_if.sv
// Stream bundle for the TC/SM converter: input beat channel plus result channel.
// Latency: none, this is wiring only.
// Backpressure: in_ready / out_ready carry valid-ready flow control in each direction.
// Ports: in_valid/in_ready/in_mode/in_data (upstream), out_valid/out_ready/out_data/out_flag (downstream).
// Modports: slave = converter side, master = side that feeds beats and consumes results.
interface tcsm_stream_if #(
    parameter int W = 12
) ();
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_flag;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flag
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flag
    );
endinterface

// File: rtl/tcsm_stream.sv
// Per-beat two's-complement <-> sign-magnitude converter (mode 0: TC->SM saturating, mode 1: SM->TC).
// Latency: 2 cycles (S1 operand + precompute, S2 selected result), 1 beat/cycle throughput.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; a stalled S2 holds its result stable.
// Ports: clk, rst_n (async active-low), bus (tcsm_stream_if.slave).
// Optional TCSM_SATCNT_EN adds sat_clr (in) and sat_count[15:0] (out): count of flagged output handshakes.
module tcsm_stream #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    tcsm_stream_if.slave bus
`ifdef TCSM_SATCNT_EN
    ,
    input  logic         sat_clr,
    output logic [15:0]  sat_count
`endif
);
    localparam int M = W - 1;  // magnitude width

    logic         s1_valid_q, s1_valid_d;
    logic         s1_mode_q,  s1_mode_d;
    logic [W-1:0] s1_data_q,  s1_data_d;
    logic [M-1:0] s1_neg_q,   s1_neg_d;
    logic         s1_mzero_q, s1_mzero_d;

    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_data_q,  s2_data_d;
    logic         s2_flag_q,  s2_flag_d;

    logic         s2_load;
    logic         s1_load;
    logic [W-1:0] res_data;
    logic         res_flag;

    always_comb begin
        s2_load = !s2_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_flag  = s2_flag_q;

    // Result select. A negative operand with non-zero low bits maps to {1, ~low+1}
    // in both modes: in mode 0 that is sign + magnitude, in mode 1 it is exactly
    // 2^W - magnitude. Only the all-zero-low-bits case differs between modes.
    always_comb begin
        res_flag = 1'b0;
        res_data = {1'b1, s1_neg_q};
        if (!s1_data_q[W-1]) begin
            res_data = s1_data_q;
        end else if (s1_mzero_q) begin
            res_flag = 1'b1;
            res_data = s1_mode_q ? '0 : {1'b1, {M{1'b1}}};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_neg_d   = s1_neg_q;
        s1_mzero_d = s1_mzero_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flag_d  = s2_flag_q;

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            // Payload only changes when a real beat moves in, so out_data keeps
            // its last value across bubbles.
            if (s1_valid_q) begin
                s2_data_d = res_data;
                s2_flag_d = res_flag;
            end
        end

        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_mode_d  = bus.in_mode;
                s1_data_d  = bus.in_data;
                s1_neg_d   = ~bus.in_data[M-1:0] + M'(1);
                s1_mzero_d = (bus.in_data[M-1:0] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_neg_q   <= '0;
            s1_mzero_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_flag_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s1_neg_q   <= s1_neg_d;
            s1_mzero_q <= s1_mzero_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flag_q  <= s2_flag_d;
        end
    end

`ifdef TCSM_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (s2_valid_q && bus.out_ready && s2_flag_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif
endmodule

// File: tb/tb_tcsm_stream.sv
// Self-checking bench for tcsm_stream (W=12): directed conversions, latency, backpressure, reset, random.
// Latency: expects results two cycles after a beat is presented when the output is not stalled.
// Backpressure: drives out_ready patterns and checks in_ready against pipeline occupancy.
module tb_tcsm_stream;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tcsm_stream_if #(.W(W)) bus ();

`ifdef TCSM_SATCNT_EN
    logic        sat_clr;
    logic [15:0] sat_count;
`endif

    tcsm_stream #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef TCSM_SATCNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [W:0]   exp_q[$];     // {flag, data} of accepted beats, oldest first
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_flag;
    logic         last_acc, last_ovld, last_irdy, last_oflag;
    logic [W-1:0] last_odata;
    int           cnt_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion from the arithmetic definition; returns {flag, data}.
    function automatic logic [W:0] model(input logic m, input logic [W-1:0] d);
        int   v;
        int   mag;
        logic s;
        logic [W:0] r;
        s = d[W-1];
        if (!m) begin
            v = s ? (int'(d) - (1 << W)) : int'(d);
            if (v == -(1 << (W-1))) begin
                r = {1'b1, 1'b1, {(W-1){1'b1}}};
            end else begin
                mag = (v < 0) ? -v : v;
                r = {1'b0, s, mag[W-2:0]};
            end
        end else begin
            mag = int'(d[W-2:0]);
            if (s && mag == 0) begin
                r = {1'b1, {W{1'b0}}};
            end else begin
                v = s ? -mag : mag;
                r = {1'b0, v[W-1:0]};
            end
        end
        return r;
    endfunction

    // One clock cycle: drive at negedge, sample 1 time unit later, score, then wait for posedge.
    task automatic step(input logic v, input logic m, input logic [W-1:0] d, input logic ordy);
        logic [W:0] e;
        logic       hs;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        hs = bus.out_valid && bus.out_ready;
        e  = '0;
        chk("in_ready", bus.in_ready, (exp_q.size() < 2) || ordy);
        if (hold_pend) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out_data, hold_data);
            chk("hold_flag", bus.out_flag, hold_flag);
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e[W-1:0]);
                chk("out_flag", bus.out_flag, e[W]);
            end
        end
`ifdef TCSM_SATCNT_EN
        chk("sat_count", sat_count, cnt_m);
        if (sat_clr) cnt_m = 0;
        else if (hs && e[W] && cnt_m != 65535) cnt_m++;
`endif
        hold_pend  = bus.out_valid && !bus.out_ready;
        hold_data  = bus.out_data;
        hold_flag  = bus.out_flag;
        last_ovld  = bus.out_valid;
        last_odata = bus.out_data;
        last_oflag = bus.out_flag;
        last_irdy  = bus.in_ready;
        last_acc   = v && bus.in_ready;
        if (last_acc) exp_q.push_back(model(m, d));
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'b1);
    endtask

    // Presents one beat into an empty pipe and checks timing plus the tabulated result.
    task automatic directed(input string tag, input logic m, input logic [W-1:0] d,
                            input logic [W-1:0] xd, input logic xf);
        step(1'b1, m, d, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk({tag, "_lat1"}, last_ovld, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk({tag, "_lat2"}, last_ovld, 1'b1);
        chk({tag, "_data"}, last_odata, xd);
        chk({tag, "_flag"}, last_oflag, xf);
    endtask

    initial begin
        int         idx;
        int         cyc;
        logic       saw_stall;
        logic [3:0] pat;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef TCSM_SATCNT_EN
        sat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_flag", bus.out_flag, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
`ifdef TCSM_SATCNT_EN
        chk("rst_sat_count", sat_count, 16'd0);
`endif

        // Tabulated conversions
        directed("tc_pos",   1'b0, 12'h005, 12'h005, 1'b0);
        directed("tc_m1",    1'b0, 12'hFFF, 12'h801, 1'b0);
        directed("tc_neg",   1'b0, 12'h801, 12'hFFF, 1'b0);
        directed("tc_sat",   1'b0, 12'h800, 12'hFFF, 1'b1);
        directed("sm_neg",   1'b1, 12'h805, 12'hFFB, 1'b0);
        directed("sm_nzero", 1'b1, 12'h800, 12'h000, 1'b1);
        directed("sm_max",   1'b1, 12'h7FF, 12'h7FF, 1'b0);

        // Backpressure: stream 0..9 with out_ready cycling 1,0,0,1
        idx = 0;
        cyc = 0;
        saw_stall = 1'b0;
        pat = 4'b1001;
        while ((idx < 10 || exp_q.size() > 0) && cyc < 200) begin
            step(idx < 10, 1'b0, W'(idx), pat[cyc % 4]);
            if (!last_irdy) saw_stall = 1'b1;
            if (last_acc) idx++;
            cyc++;
        end
        chk("bp_sent", idx, 10);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_stall_seen", saw_stall, 1'b1);

        // Asynchronous reset with both stages full
        step(1'b1, 1'b0, 12'h800, 1'b0);
        step(1'b1, 1'b1, 12'h123, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0);
        chk("full_in_ready", last_irdy, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
`ifdef TCSM_SATCNT_EN
        chk("mid_rst_sat_count", sat_count, 16'd0);
`endif
        exp_q.delete();
        hold_pend = 1'b0;
        cnt_m = 0;
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_empty", last_ovld, 1'b0);
        directed("post_rst", 1'b1, 12'h805, 12'hFFB, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("rand_drained", exp_q.size(), 0);
        // Edge-heavy random: operands restricted to the special codes
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'($urandom), ($urandom_range(0, 1) != 0) ? 12'h800 : 12'h000, 1'($urandom));
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("edge_drained", exp_q.size(), 0);

`ifdef TCSM_SATCNT_EN
        for (int i = 0; i < 65535; i++) step(1'b1, 1'b0, 12'h800, 1'b1);
        idle(3);
        chk("cnt_full", sat_count, 16'hFFFF);
        step(1'b1, 1'b0, 12'h800, 1'b1);
        idle(3);
        chk("cnt_stuck", sat_count, 16'hFFFF);
        step(1'b1, 1'b0, 12'h800, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        sat_clr = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1);
        chk("clr_with_hs", last_oflag && last_ovld, 1'b1);
        sat_clr = 1'b0;
        step(1'b0, 1'b0, '0, 1'b1);
        chk("cnt_cleared", sat_count, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
